// File: rtl/cnn_layer_sequencer.sv
// Sequences one CNN inference: streams pixel addresses, runs conv/pool/fc in turn,
// and reports the predicted class. Each layer wait is guarded by a timeout.
module cnn_layer_sequencer #(
  parameter int unsigned NUM_PIX     = 784,
  parameter int unsigned LOGIT_W     = 8,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_in,
  output logic               busy,
  output logic               load_en,
  output logic [9:0]         load_addr,
  output logic               conv_start,
  output logic               pool_start,
  output logic               fc_start,
  input  logic               conv_done,
  input  logic               pool_done,
  input  logic               fc_done,
  input  logic [LOGIT_W-1:0] logit0,
  input  logic [LOGIT_W-1:0] logit1,
  output logic               valid_out,
  output logic               pred_class,
  output logic               err
);

  localparam int unsigned PIX_W  = 10;
  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CONV, S_POOL, S_FC, S_DECIDE, S_ERR
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [PIX_W-1:0]    r_pix;
  logic [WAIT_W-1:0]   r_wait;
  logic                r_vin_q;
  logic                r_err;
  logic                r_pred;
  logic                w_start_req;
  logic                w_first;
  logic                w_timeout;
  logic                w_last_pix;
  logic                w_wait_state;
  logic                w_idle_like;

  // r_vin_q resets high so a valid_in held across reset release does not start a run
  assign w_start_req  = valid_in & ~r_vin_q;
  assign w_first      = (r_wait == '0);
  assign w_timeout    = (r_wait == WAIT_W'(TIMEOUT_CYC - 1));
  assign w_last_pix   = (r_pix == PIX_W'(NUM_PIX - 1));
  assign w_wait_state = (r_state == S_CONV) || (r_state == S_POOL) || (r_state == S_FC);
  assign w_idle_like  = (r_state == S_IDLE) || (r_state == S_ERR);

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // next-state logic; a done coinciding with its own start pulse is ignored
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_ERR: if (w_start_req) w_next = S_LOAD;
      S_LOAD:        if (w_last_pix) w_next = S_CONV;
      S_CONV: begin
        if (!w_first && conv_done) w_next = S_POOL;
        else if (w_timeout)        w_next = S_ERR;
      end
      S_POOL: begin
        if (!w_first && pool_done) w_next = S_FC;
        else if (w_timeout)        w_next = S_ERR;
      end
      S_FC: begin
        if (!w_first && fc_done) w_next = S_DECIDE;
        else if (w_timeout)      w_next = S_ERR;
      end
      S_DECIDE:      w_next = S_IDLE;
      default:       w_next = S_IDLE;
    endcase
  end

  // counters, sticky error and class register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pix   <= '0;
      r_wait  <= '0;
      r_vin_q <= 1'b1;
      r_err   <= 1'b0;
      r_pred  <= 1'b0;
    end else begin
      r_vin_q <= valid_in;
      if (r_state == S_LOAD)
        r_pix <= w_last_pix ? '0 : r_pix + PIX_W'(1);
      else if (w_idle_like && w_start_req)
        r_pix <= '0;

      if (w_next != r_state) r_wait <= '0;
      else if (w_wait_state) r_wait <= r_wait + WAIT_W'(1);

      if (w_idle_like && w_start_req)               r_err <= 1'b0;
      else if (w_next == S_ERR && r_state != S_ERR) r_err <= 1'b1;

      // tie resolves to class 1
      if (r_state == S_FC && w_next == S_DECIDE)
        r_pred <= (logit0 > logit1) ? 1'b0 : 1'b1;
    end
  end

  // output decode from registered state
  always_comb begin
    busy       = (r_state != S_IDLE);
    load_en    = (r_state == S_LOAD);
    load_addr  = r_pix;
    conv_start = (r_state == S_CONV) && w_first;
    pool_start = (r_state == S_POOL) && w_first;
    fc_start   = (r_state == S_FC)   && w_first;
    valid_out  = (r_state == S_DECIDE);
    pred_class = r_pred;
    err        = r_err;
  end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Bench for cnn_layer_sequencer: table of logit pairs run as full images, plus
// hand-written early/stray done, timeout, busy restart and reset sequences.
module tb_cnn_layer_sequencer;

  localparam int unsigned NUM_PIX     = 784;
  localparam int unsigned LOGIT_W     = 8;
  localparam int unsigned TIMEOUT_CYC = 100;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               valid_in = 1'b0;
  logic               conv_done = 1'b0, pool_done = 1'b0, fc_done = 1'b0;
  logic [LOGIT_W-1:0] logit0 = '0, logit1 = '0;
  logic               busy, load_en, conv_start, pool_start, fc_start;
  logic               valid_out, pred_class, err;
  logic [9:0]         load_addr;

  cnn_layer_sequencer #(
    .NUM_PIX(NUM_PIX), .LOGIT_W(LOGIT_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .busy(busy),
    .load_en(load_en), .load_addr(load_addr),
    .conv_start(conv_start), .pool_start(pool_start), .fc_start(fc_start),
    .conv_done(conv_done), .pool_done(pool_done), .fc_done(fc_done),
    .logit0(logit0), .logit1(logit1),
    .valid_out(valid_out), .pred_class(pred_class), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] l0;
    logic [7:0] l1;
    logic       exp_cls;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic exp_q[$];
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // scoreboard pop on each result pulse, plus start-exclusivity check
  always @(negedge clk) begin
    if (valid_out) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_valid_out: got valid_out=1 expected none at %0t", $time);
      end else begin
        chk("pred_class", 32'(pred_class), 32'(exp_q.pop_front()));
      end
    end
    if (conv_start || pool_start || fc_start)
      chk("start_exclusive", 32'({load_en, 2'(conv_start) + 2'(pool_start) + 2'(fc_start)}), 32'(1));
  end

  task automatic start_image();
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
  endtask

  // expects to be in cycle 1 (address 0); leaves in the conv_start cycle
  task automatic run_loads(input int poke);
    int bad = 0;
    for (int i = 0; i < int'(NUM_PIX); i++) begin
      if (i == poke + 1) chk("busy_vin_ignored_addr", 32'(load_addr), 32'(i));
      if (!(load_en === 1'b1 && load_addr === 10'(i) && !conv_start && !pool_start && !fc_start))
        bad++;
      if (i == poke) valid_in = 1'b1;
      step();
      valid_in = 1'b0;
    end
    chk("load_seq_errors", 32'(bad), 32'(0));
    chk("conv_start_after_load", 32'({conv_start, load_en}), 32'(2'b10));
  endtask

  task automatic pulse_done(input int which, input int dly);
    for (int k = 0; k < dly; k++) step();
    case (which)
      0:       conv_done = 1'b1;
      1:       pool_done = 1'b1;
      default: fc_done   = 1'b1;
    endcase
    step();
    conv_done = 1'b0;
    pool_done = 1'b0;
    fc_done   = 1'b0;
  endtask

  // from the pool_start cycle to the first IDLE cycle after DECIDE
  task automatic finish_from_pool(input logic [7:0] l0, input logic [7:0] l1,
                                  input logic e, input int dly);
    chk("pool_start", 32'(pool_start), 32'(1));
    pulse_done(1, dly);
    chk("fc_start", 32'(fc_start), 32'(1));
    logit0 = l0;
    logit1 = l1;
    exp_q.push_back(e);
    pulse_done(2, dly);
    chk("valid_out_decide", 32'(valid_out), 32'(1));
    logit0 = 8'($urandom);
    logit1 = 8'($urandom);
    step();
    chk("idle_after_decide", 32'({busy, valid_out}), 32'(0));
    chk("pred_hold", 32'(pred_class), 32'(e));
  endtask

  initial begin
    tbl[0] = '{8'h50, 8'h20, 1'b0};
    tbl[1] = '{8'h40, 8'h40, 1'b1};
    tbl[2] = '{8'h10, 8'hF0, 1'b1};
    tbl[3] = '{8'hFF, 8'h00, 1'b0};
    tbl[4] = '{8'h00, 8'h00, 1'b1};
    tbl[5] = '{8'h81, 8'h80, 1'b0};

    // reset values, and release with valid_in held high must not start
    valid_in = 1'b1;
    #1;
    chk("reset_outputs", 32'({busy, load_en, conv_start, pool_start, fc_start,
                              valid_out, pred_class, err}), 32'(0));
    chk("reset_addr", 32'(load_addr), 32'(0));
    #23 rst = 1'b1;
    repeat (5) step();
    chk("no_start_on_release", 32'(busy), 32'(0));
    valid_in = 1'b0;
    step();

    for (int t = 0; t < 6; t++) begin
      start_image();
      chk("busy_in_load", 32'(busy), 32'(1));
      run_loads(-1);
      pulse_done(0, 10);
      finish_from_pool(tbl[t].l0, tbl[t].l1, tbl[t].exp_cls, 10);
    end

    // early conv_done with conv_start, stray fc_done during CONV
    start_image();
    run_loads(-1);
    conv_done = 1'b1;
    step();
    conv_done = 1'b0;
    chk("early_done_ignored", 32'({busy, pool_start}), 32'(2'b10));
    fc_done = 1'b1;
    step();
    fc_done = 1'b0;
    repeat (3) step();
    chk("stray_done_ignored", 32'({busy, pool_start, fc_start}), 32'(3'b100));
    conv_done = 1'b1;
    step();
    conv_done = 1'b0;
    finish_from_pool(8'h30, 8'h31, 1'b1, 4);

    // pool_done never returned
    start_image();
    run_loads(-1);
    pulse_done(0, 5);
    chk("pool_start_to", 32'(pool_start), 32'(1));
    repeat (TIMEOUT_CYC - 1) step();
    chk("err_before_timeout", 32'(err), 32'(0));
    step();
    chk("err_at_timeout", 32'({err, busy}), 32'(2'b11));
    repeat (10) step();
    chk("err_sticky", 32'({err, valid_out, load_en}), 32'(3'b100));
    start_image();
    chk("restart_clears_err", 32'({err, load_en, load_addr}), 32'({2'b01, 10'd0}));
    run_loads(300);
    pulse_done(0, 2);
    finish_from_pool(8'h90, 8'h10, 1'b0, 2);

    // reset asserted during FC aborts the image
    start_image();
    run_loads(-1);
    pulse_done(0, 3);
    chk("pool_start_rst", 32'(pool_start), 32'(1));
    pulse_done(1, 3);
    chk("fc_start_rst", 32'(fc_start), 32'(1));
    step();
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_fc_outputs", 32'({busy, load_en, conv_start, pool_start, fc_start,
                                  valid_out, err}), 32'(0));
    chk("rst_mid_fc_addr", 32'(load_addr), 32'(0));
    fc_done = 1'b1;
    step();
    fc_done = 1'b0;
    rst = 1'b1;
    repeat (20) step();
    chk("idle_after_rst", 32'({busy, valid_out}), 32'(0));
    chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
